// File: rtl/decode_prefix_accumulator.sv
// Multi-cycle prefix accumulator: consumes leading prefix bytes from each fetch
// window and hands the accumulated prefix bundle to the opcode stage.
module decode_prefix_accumulator #(
    parameter  int WINDOW_BYTES = 4,
    parameter  int MAX_PREFIX   = 14,
    localparam int CNT_W        = $clog2(MAX_PREFIX + WINDOW_BYTES + 1),
    localparam int AW           = $clog2(WINDOW_BYTES + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_flush,
    input  logic                      i_valid,
    input  logic [8*WINDOW_BYTES-1:0] i_bytes,
    input  logic [AW-1:0]             i_avail,
    output logic                      o_ready,
    output logic [AW-1:0]             o_consume,
    output logic                      o_pfx_valid,
    input  logic                      i_pfx_ready,
    output logic                      o_lock,
    output logic                      o_repne,
    output logic                      o_rep,
    output logic                      o_opsize,
    output logic                      o_adsize,
    output logic                      o_seg_override,
    output logic [2:0]                o_seg_index,
    output logic                      o_hint_not_taken,
    output logic                      o_hint_taken,
    output logic [CNT_W-1:0]          o_pfx_count,
    output logic                      o_pfx_error_repeat,
    output logic                      o_pfx_error_length
);

    typedef enum logic {SCAN, DONE} state_t;

    typedef struct packed {
        logic             lock;
        logic             repne;
        logic             rep;
        logic             opsize;
        logic             adsize;
        logic             seg_override;
        logic [2:0]       seg_index;
        logic             hint_not_taken;
        logic             hint_taken;
        logic [CNT_W-1:0] count;
        logic             err_repeat;
        logic             err_length;
    } bundle_t;

    // Group number of a prefix byte; 0 means the byte is not a prefix.
    function automatic logic [2:0] pfx_group(input logic [7:0] b);
        case (b)
            8'hF0, 8'hF2, 8'hF3:                      pfx_group = 3'd1;
            8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: pfx_group = 3'd2;
            8'h66:                                    pfx_group = 3'd3;
            8'h67:                                    pfx_group = 3'd4;
            default:                                  pfx_group = 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] seg_code(input logic [7:0] b);
        case (b)
            8'h2E:   seg_code = 3'd1;
            8'h36:   seg_code = 3'd2;
            8'h3E:   seg_code = 3'd3;
            8'h64:   seg_code = 3'd4;
            8'h65:   seg_code = 3'd5;
            default: seg_code = 3'd0;
        endcase
    endfunction

    state_t          state;
    bundle_t         bndl;
    bundle_t         n_bndl;
    logic [AW-1:0]   k;
    logic            stop;
    logic            g1, g2, g3, g4;
    logic [7:0]      b;
    logic [CNT_W:0]  sum;
    logic            opcode_hit;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        k      = '0;
        stop   = 1'b0;
        b      = '0;
        n_bndl = bndl;
        g1     = bndl.lock | bndl.repne | bndl.rep;
        g2     = bndl.seg_override;
        g3     = bndl.opsize;
        g4     = bndl.adsize;

        for (int i = 0; i < WINDOW_BYTES; i++) begin
            b = i_bytes[8*i +: 8];
            if (!stop && (AW'(i) < i_avail) && (pfx_group(b) != 3'd0)) k = k + AW'(1);
            else stop = 1'b1;
        end

        // Walk consumed bytes in stream order so "last segment wins" falls out naturally.
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            b = i_bytes[8*i +: 8];
            if (AW'(i) < k) begin
                case (pfx_group(b))
                    3'd1: begin
                        if (g1) n_bndl.err_repeat = 1'b1;
                        g1 = 1'b1;
                        if (b == 8'hF0) n_bndl.lock  = 1'b1;
                        if (b == 8'hF2) n_bndl.repne = 1'b1;
                        if (b == 8'hF3) n_bndl.rep   = 1'b1;
                    end
                    3'd2: begin
                        if (g2) n_bndl.err_repeat = 1'b1;
                        g2 = 1'b1;
                        n_bndl.seg_override   = 1'b1;
                        n_bndl.seg_index      = seg_code(b);
                        n_bndl.hint_not_taken = (b == 8'h2E);
                        n_bndl.hint_taken     = (b == 8'h3E);
                    end
                    3'd3: begin
                        if (g3) n_bndl.err_repeat = 1'b1;
                        g3 = 1'b1;
                        n_bndl.opsize = 1'b1;
                    end
                    3'd4: begin
                        if (g4) n_bndl.err_repeat = 1'b1;
                        g4 = 1'b1;
                        n_bndl.adsize = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        sum              = {1'b0, bndl.count} + (CNT_W+1)'(k);
        n_bndl.count     = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        n_bndl.err_length = bndl.err_length | (n_bndl.count > CNT_W'(MAX_PREFIX));
        opcode_hit       = (k < i_avail);
    end

    assign o_ready   = (state == SCAN);
    assign o_consume = (state == SCAN && i_valid && !i_flush) ? k : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state       <= SCAN;
            bndl        <= '0;
            o_pfx_valid <= 1'b0;
        end else if (i_flush) begin
            state       <= SCAN;
            bndl        <= '0;
            o_pfx_valid <= 1'b0;
        end else begin
            case (state)
                SCAN: if (i_valid) begin
                    bndl <= n_bndl;
                    if (opcode_hit) begin
                        state       <= DONE;
                        o_pfx_valid <= 1'b1;
                    end
                end
                DONE: if (i_pfx_ready) begin
                    state       <= SCAN;
                    bndl        <= '0;
                    o_pfx_valid <= 1'b0;
                end
                default: state <= SCAN;
            endcase
        end
    end

    assign o_lock             = bndl.lock;
    assign o_repne            = bndl.repne;
    assign o_rep              = bndl.rep;
    assign o_opsize           = bndl.opsize;
    assign o_adsize           = bndl.adsize;
    assign o_seg_override     = bndl.seg_override;
    assign o_seg_index        = bndl.seg_index;
    assign o_hint_not_taken   = bndl.hint_not_taken;
    assign o_hint_taken       = bndl.hint_taken;
    assign o_pfx_count        = bndl.count;
    assign o_pfx_error_repeat = bndl.err_repeat;
    assign o_pfx_error_length = bndl.err_length;

endmodule

// File: tb/tb_decode_prefix_accumulator.sv
// Scoreboard bench for decode_prefix_accumulator: directed windows push expected
// bundles; a monitor pops and compares on each bundle handshake.
module tb_decode_prefix_accumulator;

    localparam int W  = 4;
    localparam int CW = 5;
    localparam int AW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_flush = 1'b0;
    logic           i_valid = 1'b0;
    logic [8*W-1:0] i_bytes = '0;
    logic [AW-1:0]  i_avail = '0;
    logic           i_pfx_ready = 1'b1;
    logic           o_ready, o_pfx_valid;
    logic [AW-1:0]  o_consume;
    logic           o_lock, o_repne, o_rep, o_opsize, o_adsize;
    logic           o_seg_override, o_hint_not_taken, o_hint_taken;
    logic [2:0]     o_seg_index;
    logic [CW-1:0]  o_pfx_count;
    logic           o_pfx_error_repeat, o_pfx_error_length;

    int checks   = 0;
    int failures = 0;
    logic [17:0] exp_q[$];
    logic [17:0] dut_b;

    decode_prefix_accumulator #(.WINDOW_BYTES(W), .MAX_PREFIX(14)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid),
        .i_bytes(i_bytes), .i_avail(i_avail), .o_ready(o_ready),
        .o_consume(o_consume), .o_pfx_valid(o_pfx_valid), .i_pfx_ready(i_pfx_ready),
        .o_lock(o_lock), .o_repne(o_repne), .o_rep(o_rep), .o_opsize(o_opsize),
        .o_adsize(o_adsize), .o_seg_override(o_seg_override), .o_seg_index(o_seg_index),
        .o_hint_not_taken(o_hint_not_taken), .o_hint_taken(o_hint_taken),
        .o_pfx_count(o_pfx_count), .o_pfx_error_repeat(o_pfx_error_repeat),
        .o_pfx_error_length(o_pfx_error_length)
    );

    always #5 clk = ~clk;

    assign dut_b = {o_lock, o_repne, o_rep, o_opsize, o_adsize, o_seg_override, o_seg_index,
                    o_hint_not_taken, o_hint_taken, o_pfx_count,
                    o_pfx_error_repeat, o_pfx_error_length};

    function automatic logic [17:0] mk(input logic lock, repne, rep, op, ad, so,
                                       input logic [2:0] si, input logic hnt, ht,
                                       input logic [CW-1:0] cnt, input logic er, el);
        mk = {lock, repne, rep, op, ad, so, si, hnt, ht, cnt, er, el};
    endfunction

    function automatic logic [8*W-1:0] win(input logic [7:0] b0, b1, b2, b3);
        win = {b3, b2, b1, b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one window at posedge+1, check the combinational consume, release after the edge.
    task automatic send(input string name, input logic [8*W-1:0] bytes,
                        input logic [AW-1:0] avail, input logic [AW-1:0] exp_consume);
        i_valid = 1'b1;
        i_bytes = bytes;
        i_avail = avail;
        @(negedge clk);
        check({name, "_consume"}, 32'(o_consume), 32'(exp_consume));
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_scan(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (o_ready) seen = 1'b1;
        end
        check({name, "_back_to_scan"}, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake must match the oldest expected bundle.
    always @(negedge clk) begin
        if (rst_n && o_pfx_valid && i_pfx_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bundle", 32'(dut_b), 32'h3FFFF);
            end else begin
                check("bundle", 32'(dut_b), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && i_valid) assert (i_avail != 0) else $error("i_avail=0 with i_valid");
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_bundle", 32'(dut_b), 32'd0);
        check("reset_valid", 32'(o_pfx_valid), 32'd0);
        check("reset_ready", 32'(o_ready), 32'd1);
        check("reset_consume", 32'(o_consume), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 66 F3 then opcode A5
        exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 3'd0, 0, 0, 5'd2, 0, 0));
        send("t1", win(8'h66, 8'hF3, 8'hA5, 8'h00), 3'd4, 3'd2);
        wait_scan("t1");

        // 15 CS prefixes across four windows: repeat and length errors
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 3'd1, 1, 0, 5'd15, 1, 1));
        send("t2a", win(8'h2E, 8'h2E, 8'h2E, 8'h2E), 3'd4, 3'd4);
        send("t2b", win(8'h2E, 8'h2E, 8'h2E, 8'h2E), 3'd4, 3'd4);
        send("t2c", win(8'h2E, 8'h2E, 8'h2E, 8'h2E), 3'd4, 3'd4);
        send("t2d", win(8'h2E, 8'h2E, 8'h2E, 8'h90), 3'd4, 3'd3);
        wait_scan("t2");

        // Bytes beyond i_avail are ignored; FS wins over ES
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 3'd4, 0, 0, 5'd3, 1, 0));
        send("t3a", win(8'h26, 8'hF0, 8'h66, 8'h66), 3'd2, 3'd2);
        send("t3b", win(8'h64, 8'h8B, 8'h66, 8'h66), 3'd4, 3'd1);
        wait_scan("t3");

        // Zero-prefix instruction with opcode stage back-pressure
        i_pfx_ready = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 5'd0, 0, 0));
        send("t4", win(8'h90, 8'h66, 8'h66, 8'h66), 3'd4, 3'd0);
        for (int c = 0; c < 3; c++) begin
            i_valid = 1'b1;
            i_bytes = win(8'h66, 8'hF0, 8'h67, 8'h2E);
            i_avail = 3'd4;
            @(negedge clk);
            check("t4_stall_ready", 32'(o_ready), 32'd0);
            check("t4_stall_consume", 32'(o_consume), 32'd0);
            check("t4_stall_bundle", 32'({o_pfx_valid, dut_b}), 32'({1'b1, 18'd0}));
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_pfx_ready = 1'b1;
        wait_scan("t4");

        // Flush while accumulating drops the partial bundle
        send("t5a", win(8'h67, 8'h66, 8'hF2, 8'hF2), 3'd4, 3'd4);
        check("t5_accum_count", 32'(o_pfx_count), 32'd4);
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_bytes = win(8'h66, 8'h90, 8'h00, 8'h00);
        @(negedge clk);
        check("t5_flush_consume", 32'(o_consume), 32'd0);
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        check("t5_flushed_bundle", 32'({o_pfx_valid, dut_b}), 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 5'd0, 0, 0));
        send("t5b", win(8'h0F, 8'h66, 8'h00, 8'h00), 3'd4, 3'd0);
        wait_scan("t5");

        // Flush while holding a bundle in DONE
        i_pfx_ready = 1'b0;
        send("t5c", win(8'hF3, 8'h90, 8'h00, 8'h00), 3'd4, 3'd1);
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        @(negedge clk);
        check("t5_done_flush", 32'({o_pfx_valid, o_ready, dut_b}), 32'({2'b01, 18'd0}));
        @(posedge clk);
        #1;
        i_pfx_ready = 1'b1;

        // Async reset mid-scan
        send("t6", win(8'hF0, 8'h66, 8'h67, 8'h90), 3'd3, 3'd3);
        @(negedge clk);
        check("t6_accum_count", 32'(o_pfx_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_bundle", 32'({o_pfx_valid, dut_b}), 32'd0);
        check("t6_async_ready", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_release_ready", 32'(o_ready), 32'd1);

        repeat (2) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
